circ_buff_read_addr_gen: RTL

- Upstream address stage of the circ_buff_read_many128 read path.
- Accepts one read request per handshake (buffer id, start read pointer, word count), computes the buffer base as buf_id × stride with the 8×16→24 unsigned product, then streams one 24-bit word address per cycle.
- The read pointer wraps circularly inside the selected buffer.
- Reports the updated read pointer when the request completes.

---
 rtl/circ_buff_read_addr_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/circ_buff_read_addr_gen.sv
// circ_buff_read_addr_gen: read address generator for circular buffers.
// Accepts one request (buffer id, start pointer, length), computes the
// buffer base as buf_id * stride, then streams one word address per
// handshake, wrapping the pointer circularly inside the selected buffer.
// On completion it pulses done with the updated pointer or an error.
//
// Ports:
//   ap_clk, ap_rst_n      clock, async active-low reset
//   cfg_stride            words per buffer, sampled at request accept
//   req_*                 request handshake (valid/ready, buf_id, rd_ptr, len)
//   addr_*                address stream (valid/ready, data)
//   done_*                completion pulse, final pointer, error flag
//
// Optional feature (macro CIRC_BUFF_ADDR_LAST_EN):
//   adds addr_last, high with addr_valid on the final address of a request.
//
// ADDR_W must equal ID_W + PTR_W (full-width base product).

module circ_buff_read_addr_gen #(
    parameter int ID_W   = 8,
    parameter int PTR_W  = 16,
    parameter int ADDR_W = 24
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PTR_W-1:0]  cfg_stride,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_buf_id,
    input  logic [PTR_W-1:0]  req_rd_ptr,
    input  logic [PTR_W-1:0]  req_len,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr_data,
`ifdef CIRC_BUFF_ADDR_LAST_EN
    output logic              addr_last,
`endif
    output logic              done_valid,
    output logic [PTR_W-1:0]  done_rd_ptr,
    output logic              done_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    id_q;
    logic [PTR_W-1:0]   stride_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   len_q;
    logic [PTR_W-1:0]   rem_q;
    logic [ADDR_W-1:0]  base_q;

    logic [ADDR_W-1:0]  prod;
    logic [PTR_W:0]     ptr_inc;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               req_err;
    logic               hs;

    // Both operands zero-extended to ADDR_W: unsigned, untruncated product.
    assign prod = {{PTR_W{1'b0}}, id_q} * {{ID_W{1'b0}}, stride_q};

    // Extra bit keeps ptr+1==stride exact at stride = 2^PTR_W-1.
    assign ptr_inc = {1'b0, ptr_q} + (PTR_W+1)'(1);
    assign ptr_nxt = (ptr_inc == {1'b0, stride_q}) ? '0 : ptr_inc[PTR_W-1:0];

    assign req_err = (stride_q == '0) || (ptr_q >= stride_q);
    assign hs      = addr_valid && addr_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            id_q        <= '0;
            stride_q    <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            req_ready   <= 1'b0;
            addr_valid  <= 1'b0;
            addr_data   <= '0;
`ifdef CIRC_BUFF_ADDR_LAST_EN
            addr_last   <= 1'b0;
`endif
            done_valid  <= 1'b0;
            done_rd_ptr <= '0;
            done_err    <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        id_q      <= req_buf_id;
                        stride_q  <= cfg_stride;
                        ptr_q     <= req_rd_ptr;
                        len_q     <= req_len;
                        req_ready <= 1'b0;
                        state     <= CALC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                CALC: begin
                    base_q <= prod;
                    rem_q  <= len_q;
                    if (req_err) begin
                        done_valid  <= 1'b1;
                        done_err    <= 1'b1;
                        done_rd_ptr <= ptr_q;
                        state       <= DONE;
                    end else if (len_q == '0) begin
                        done_valid  <= 1'b1;
                        done_err    <= 1'b0;
                        done_rd_ptr <= ptr_q;
                        state       <= DONE;
                    end else begin
                        // First address uses the product directly so it
                        // is ready the cycle after CALC.
                        addr_valid <= 1'b1;
                        addr_data  <= prod + {{ID_W{1'b0}}, ptr_q};
`ifdef CIRC_BUFF_ADDR_LAST_EN
                        addr_last  <= (len_q == PTR_W'(1));
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        ptr_q <= ptr_nxt;
                        rem_q <= rem_q - PTR_W'(1);
                        if (rem_q == PTR_W'(1)) begin
                            addr_valid  <= 1'b0;
`ifdef CIRC_BUFF_ADDR_LAST_EN
                            addr_last   <= 1'b0;
`endif
                            done_valid  <= 1'b1;
                            done_err    <= 1'b0;
                            done_rd_ptr <= ptr_nxt;
                            state       <= DONE;
                        end else begin
                            addr_data <= base_q + {{ID_W{1'b0}}, ptr_nxt};
`ifdef CIRC_BUFF_ADDR_LAST_EN
                            addr_last <= (rem_q == PTR_W'(2));
`endif
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
